file_port_sequencer: RTL and testbench
======================================

# file_port_sequencer

Drives the file port of the shared 256×16 data memory for the matrix multiplier. In load mode it assembles a byte stream from the host receiver into 16-bit words and writes them to consecutive memory addresses. In dump mode it reads consecutive words back through the same port and streams them out as bytes over a valid/ready handshake toward the host transmitter. It is the only agent driving `write_en_file`, `addr_file` and `data_file`.

## Interface
- `ADDR_W`, 8, memory address width (256 words)
- `DATA_W`, 16, memory word width; fixed at 2 bytes per word

- `clock`  in  1  system clock, rising edge
- `reset`  in  1  asynchronous, active-high reset
- `load_start`  in  1  single-cycle pulse; begin a load from IDLE
- `dump_start`  in  1  single-cycle pulse; begin a dump from IDLE
- `base_addr`  in  8  first memory address; sampled on the start pulse
- `word_count`  in  9  number of words, 0..256; sampled on the start pulse
- `rx_valid`  in  1  host byte valid; no backpressure, one byte per cycle maximum
- `rx_data`  in  8  host byte
- `tx_valid`  out  1  output byte valid
- `tx_ready`  in  1  transmitter accepts the byte
- `tx_data`  out  8  output byte
- `write_en_file`  out  1  memory file-port write enable (registered)
- `addr_file`  out  8  memory file-port address (registered)
- `data_file`  out  16  memory file-port write data (registered)
- `dataout_file`  in  16  memory file-port read data; valid one cycle after the address is presented with `write_en_file`=0
- `busy`  out  1  high in every state except IDLE
- `done`  out  1  one-cycle pulse when a load or dump completes

## Operation
- **States:** IDLE, LD_HI, LD_LO, LD_WR, DP_RD, DP_WAIT, DP_HI, DP_LO, FIN.
- **IDLE:**
  - Sample `base_addr` into the pointer and `word_count` into the remaining counter on a start pulse.
  - `load_start` goes to LD_HI. `dump_start` goes to DP_RD. If both pulse together, load wins.
  - A start pulse with `word_count`=0 goes directly to FIN. No memory access occurs.
  - `rx_valid` is ignored in IDLE.
- **Load:**
  - LD_HI: on `rx_valid`, latch `rx_data` as word[15:8] and go to LD_LO.
  - LD_LO: on `rx_valid`, latch `rx_data` as word[7:0] and go to LD_WR.
  - LD_WR: drive `write_en_file`=1, `addr_file`=pointer, `data_file`=word for exactly one cycle. Then increment the pointer and decrement the counter.
  - After LD_WR, go to LD_HI, or to FIN if the counter reaches 0.
  - A byte arriving during LD_WR is dropped. The host must leave a gap of at least one idle cycle after every second byte.
- **Dump:**
  - DP_RD: drive `addr_file`=pointer with `write_en_file`=0.
  - DP_WAIT: capture `dataout_file` into the tx word register.
  - DP_HI: assert `tx_valid` with `tx_data`=word[15:8]. On `tx_ready`, go to DP_LO.
  - DP_LO: assert `tx_valid` with `tx_data`=word[7:0]. On `tx_ready`, increment the pointer, decrement the counter, and go to DP_RD, or to FIN if the counter reaches 0.
- **FIN:** pulse `done`=1 for one cycle, then return to IDLE.
- **Pointer:** wraps modulo 256, so 255+1 = 0. A count of 256 covers the whole memory exactly once.
- **Ignored inputs:** start pulses are ignored while `busy`=1.
- **`write_en_file`:** 0 in every state except LD_WR.

## Timing
- **Reset values:**
  - `write_en_file`, `tx_valid`, `busy` and `done` are 0.
  - `addr_file`, `data_file` and `tx_data` are 0.
  - The state is IDLE.
  - Reset deasserts `write_en_file` immediately, including mid-load. A word whose second byte has not been written is discarded.
- **Load latency:**
  - Second byte accepted in cycle t.
  - Memory write strobe occurs in cycle t+1.
  - `done` follows in cycle t+2 for the last word.
- **Dump latency:**
  - Start pulse in cycle t: address presented in t+1, data captured in t+2, first `tx_valid` in t+3.
  - With `tx_ready` held high, one word takes 4 cycles.
- **Handshake:**
  - `tx_data` is stable while `tx_valid`=1 and `tx_ready`=0.
  - `tx_valid` never drops before the byte is accepted.
  - A byte transfers on the edge where `tx_valid` and `tx_ready` are both 1.
- **Ports:** all outputs are registered. No combinational path from any input to any output.

## Test plan
- **Load:** reset, then `load_start` with base=0x10, count=2, bytes 0x12,0x34,(gap),0x56,0x78 → writes (0x10,0x1234) then (0x11,0x5678), one strobe each. `done` pulses 1 cycle after the second write.
- **Dump with backpressure:** memory preloaded with 0x10=0xABCD, then `dump_start` with base=0x10, count=1, `tx_ready` low for 3 cycles → `tx_valid` rises 3 cycles after start, holds 0xAB until ready, then sends 0xCD, then `done`.
- **Wrap:** dump with base=0xFF, count=2 → reads addresses 0xFF then 0x00. Load with count=256 → exactly 256 strobes covering every address.
- **Start edge cases:** `word_count`=0 → `done` the cycle after start and no strobe. Simultaneous load and dump pulses → load mode. `dump_start` while busy → ignored.
- **Reset mid-load:** assert `reset` during LD_LO → `write_en_file`=0 immediately and `busy`=0. A subsequent load writes correctly starting from its own base.

Source files
------------

// File: rtl/file_port_sequencer.sv
// Owns the file port of the shared 256x16 data memory. It packs host bytes into words
// on load, and streams memory words out as big-endian byte pairs on dump.
module file_port_sequencer #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load_start,
  input  logic              dump_start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   word_count,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic [7:0]        tx_data,
  output logic              write_en_file,
  output logic [ADDR_W-1:0] addr_file,
  output logic [DATA_W-1:0] data_file,
  input  logic [DATA_W-1:0] dataout_file,
  output logic              busy,
  output logic              done
);

  typedef enum logic [3:0] {
    IDLE,
    LD_HI,
    LD_LO,
    LD_WR,
    DP_RD,
    DP_WAIT,
    DP_HI,
    DP_LO,
    FIN
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W:0]   remaining;
  logic [7:0]        byte_hi;
  logic [7:0]        tx_word_lo;

  // Every output is a flop. Each output is loaded on the transition into the state
  // that owns it, so it is already valid during that state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      ptr           <= '0;
      remaining     <= '0;
      byte_hi       <= '0;
      tx_word_lo    <= '0;
      write_en_file <= 1'b0;
      addr_file     <= '0;
      data_file     <= '0;
      tx_valid      <= 1'b0;
      tx_data       <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      // NOTE: non-blocking defaults at the top make pulse outputs self-clearing;
      // later assignments in the same block override them for this edge only.
      done          <= 1'b0;
      write_en_file <= 1'b0;

      case (state)
        IDLE: begin
          if (load_start || dump_start) begin
            ptr       <= base_addr;
            remaining <= word_count;
            addr_file <= base_addr;
            busy      <= 1'b1;
            if (word_count == '0) begin
              done  <= 1'b1;
              state <= FIN;
            end else if (load_start) begin
              state <= LD_HI;
            end else begin
              state <= DP_RD;
            end
          end
        end

        LD_HI: begin
          if (rx_valid) begin
            byte_hi <= rx_data;
            state   <= LD_LO;
          end
        end

        LD_LO: begin
          if (rx_valid) begin
            write_en_file <= 1'b1;
            addr_file     <= ptr;
            data_file     <= {byte_hi, rx_data};
            state         <= LD_WR;
          end
        end

        // The strobe is high for this single cycle; any rx byte arriving now is dropped.
        LD_WR: begin
          ptr       <= ptr + ADDR_W'(1);
          remaining <= remaining - (ADDR_W+1)'(1);
          if (remaining == (ADDR_W+1)'(1)) begin
            done  <= 1'b1;
            state <= FIN;
          end else begin
            state <= LD_HI;
          end
        end

        DP_RD: state <= DP_WAIT;

        // Memory read data is valid now, one cycle after the address was presented.
        DP_WAIT: begin
          tx_valid   <= 1'b1;
          tx_data    <= dataout_file[DATA_W-1 -: 8];
          tx_word_lo <= dataout_file[7:0];
          state      <= DP_HI;
        end

        DP_HI: begin
          if (tx_ready) begin
            tx_data <= tx_word_lo;
            state   <= DP_LO;
          end
        end

        DP_LO: begin
          if (tx_ready) begin
            tx_valid  <= 1'b0;
            ptr       <= ptr + ADDR_W'(1);
            remaining <= remaining - (ADDR_W+1)'(1);
            if (remaining == (ADDR_W+1)'(1)) begin
              done  <= 1'b1;
              state <= FIN;
            end else begin
              addr_file <= ptr + ADDR_W'(1);
              state     <= DP_RD;
            end
          end
        end

        FIN: begin
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_file_port_sequencer.sv
// Bench for file_port_sequencer: a behavioural memory, random stimulus, and queues of
// expected memory writes and tx bytes that an independent monitor drains.
module tb_file_port_sequencer;

  logic        clock = 1'b0;
  logic        reset;
  logic        load_start, dump_start;
  logic [7:0]  base_addr;
  logic [8:0]  word_count;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        tx_valid, tx_ready;
  logic [7:0]  tx_data;
  logic        write_en_file;
  logic [7:0]  addr_file;
  logic [15:0] data_file, dataout_file;
  logic        busy, done;

  file_port_sequencer #(.ADDR_W(8), .DATA_W(16)) dut (
    .clock(clock), .reset(reset),
    .load_start(load_start), .dump_start(dump_start),
    .base_addr(base_addr), .word_count(word_count),
    .rx_valid(rx_valid), .rx_data(rx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
    .write_en_file(write_en_file), .addr_file(addr_file),
    .data_file(data_file), .dataout_file(dataout_file),
    .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  // Synchronous-read memory attached to the file port.
  logic [15:0] mem [256];
  always @(posedge clock) begin
    if (write_en_file) mem[addr_file] <= data_file;
    dataout_file <= mem[addr_file];
  end

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int vectors = 0, miscompares = 0;
  int wr_cnt = 0, done_cnt = 0, done_cyc = 0, last_wr_cyc = 0, last_tx_cyc = 0;
  logic [23:0] exp_wr[$];
  logic [7:0]  exp_tx[$];
  logic [15:0] ref_mem [256];
  int ready_block = 0;
  bit ready_rand = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_event(input string name, input logic [31:0] act);
    vectors++;
    miscompares++;
    $display("FAIL %s: got event 0x%0h, expected none (cycle %0d)", name, act, cyc);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic start(input logic ld, input logic dp, input logic [7:0] b, input logic [8:0] c);
    load_start = ld;
    dump_start = dp;
    base_addr  = b;
    word_count = c;
    tick();
    load_start = 1'b0;
    dump_start = 1'b0;
    base_addr  = 8'($urandom);
    word_count = 9'($urandom);
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    tick();
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
  endtask

  task automatic wait_done(input int d0, input string name);
    int n = 0;
    while (done_cnt == d0 && n < 4000) begin
      tick();
      n++;
    end
    check({name, "_done_seen"}, done_cnt - d0, 1);
    check({name, "_idle_busy"}, busy, 0);
  endtask

  // Expected writes: word i goes to (base+i) mod 256 as {first byte, second byte}.
  task automatic do_load(input logic [7:0] base, input int count, input bit both,
                         input bit poke, input bit fixed, input logic [15:0] seed);
    logic [15:0] words[$];
    logic [7:0]  a;
    int d0, w0;
    d0 = done_cnt;
    w0 = wr_cnt;
    for (int i = 0; i < count; i++) begin
      logic [15:0] w;
      w = fixed ? seed + 16'(i) : 16'($urandom);
      a = base + 8'(i);
      words.push_back(w);
      exp_wr.push_back({a, w});
      ref_mem[a] = w;
    end
    start(1'b1, both, base, 9'(count));
    check("load_busy", busy, 1);
    check("load_no_tx", tx_valid, 0);
    if (count == 0) begin
      check("load_zero_done", done, 1);
      tick();
      check("load_zero_done_clear", done, 0);
      check("load_zero_busy_clear", busy, 0);
      check("load_zero_no_write", wr_cnt - w0, 0);
      return;
    end
    if (poke) begin
      dump_start = 1'b1;
      base_addr  = ~base;
      word_count = 9'd1;
      tick();
      dump_start = 1'b0;
    end
    foreach (words[i]) begin
      send_byte(words[i][15:8]);
      repeat ($urandom_range(0, 1)) tick();
      send_byte(words[i][7:0]);
      rx_valid = 1'($urandom_range(0, 1));
      rx_data  = 8'($urandom);
      tick();
      rx_valid = 1'b0;
      repeat ($urandom_range(0, 2)) tick();
    end
    wait_done(d0, "load");
    check("load_done_latency", done_cyc - last_wr_cyc, 1);
    check("load_write_count", wr_cnt - w0, count);
    check("load_queue_drained", exp_wr.size(), 0);
  endtask

  // Expected bytes: for each word at (base+i) mod 256, high byte then low byte.
  task automatic do_dump(input logic [7:0] base, input int count, input bit poke);
    logic [7:0] a;
    int d0;
    d0 = done_cnt;
    for (int i = 0; i < count; i++) begin
      a = base + 8'(i);
      exp_tx.push_back(ref_mem[a][15:8]);
      exp_tx.push_back(ref_mem[a][7:0]);
    end
    start(1'b0, 1'b1, base, 9'(count));
    check("dump_busy", busy, 1);
    if (count == 0) begin
      check("dump_zero_done", done, 1);
      check("dump_zero_no_tx", tx_valid, 0);
      tick();
      check("dump_zero_done_clear", done, 0);
      check("dump_zero_busy_clear", busy, 0);
      return;
    end
    check("dump_first_addr", addr_file, base);
    check("dump_read_only", write_en_file, 0);
    if (poke) begin
      load_start = 1'b1;
      base_addr  = ~base;
      word_count = 9'd1;
      tick();
      load_start = 1'b0;
    end
    wait_done(d0, "dump");
    check("dump_done_latency", done_cyc - last_tx_cyc, 1);
    check("dump_queue_drained", exp_tx.size(), 0);
    check("dump_tx_idle", tx_valid, 0);
  endtask

  // Downstream readiness: forced low for ready_block cycles, otherwise random or high.
  initial begin
    tx_ready = 1'b0;
    forever begin
      @(posedge clock);
      #2;
      if (ready_block > 0) begin
        tx_ready = 1'b0;
        ready_block--;
      end else begin
        tx_ready = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      end
    end
  end

  // Monitor: pops expectations whenever the DUT writes memory or hands over a byte.
  initial begin : monitor
    logic        pv, pr;
    logic [7:0]  pd;
    logic [23:0] ew;
    logic [7:0]  eb;
    pv = 1'b0; pr = 1'b0; pd = '0;
    forever begin
      @(negedge clock);
      if (reset) begin
        pv = 1'b0;
        continue;
      end
      if (write_en_file) begin
        wr_cnt++;
        last_wr_cyc = cyc;
        if (exp_wr.size() == 0) fail_event("unexpected_write", {addr_file, data_file});
        else begin
          ew = exp_wr.pop_front();
          check("mem_write", {addr_file, data_file}, ew);
        end
      end
      if (pv && !pr) begin
        check("tx_hold_valid", tx_valid, 1);
        check("tx_hold_data", tx_data, pd);
      end
      if (tx_valid && tx_ready) begin
        last_tx_cyc = cyc;
        if (exp_tx.size() == 0) fail_event("unexpected_tx", tx_data);
        else begin
          eb = exp_tx.pop_front();
          check("tx_byte", tx_data, eb);
        end
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      pv = tx_valid;
      pr = tx_ready;
      pd = tx_data;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b;
    reset = 1'b1;
    load_start = 1'b0; dump_start = 1'b0;
    base_addr = '0; word_count = '0;
    rx_valid = 1'b0; rx_data = '0;
    repeat (2) @(posedge clock);
    #1;
    check("rst_write_en", write_en_file, 0);
    check("rst_tx_valid", tx_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_addr", addr_file, 0);
    check("rst_data", data_file, 0);
    check("rst_tx_data", tx_data, 0);
    reset = 1'b0;
    tick();

    // Directed load: two words with a gap after the second byte of each.
    exp_wr.push_back({8'h10, 16'h1234});
    exp_wr.push_back({8'h11, 16'h5678});
    ref_mem[8'h10] = 16'h1234;
    ref_mem[8'h11] = 16'h5678;
    start(1'b1, 1'b0, 8'h10, 9'd2);
    check("ld_busy", busy, 1);
    send_byte(8'h12);
    send_byte(8'h34);
    check("ld_strobe0", write_en_file, 1);
    check("ld_addr0", addr_file, 8'h10);
    check("ld_data0", data_file, 16'h1234);
    tick();
    check("ld_strobe0_once", write_en_file, 0);
    send_byte(8'h56);
    send_byte(8'h78);
    check("ld_strobe1", write_en_file, 1);
    check("ld_addr1", addr_file, 8'h11);
    check("ld_data1", data_file, 16'h5678);
    tick();
    check("ld_done", done, 1);
    check("ld_strobe1_once", write_en_file, 0);
    tick();
    check("ld_done_pulse", done, 0);
    check("ld_idle", busy, 0);

    // Directed dump of 0xABCD with tx_ready held low across the first three valid cycles.
    do_load(8'h10, 1, 1'b0, 1'b0, 1'b1, 16'hABCD);
    ready_rand = 1'b0;
    exp_tx.push_back(8'hAB);
    exp_tx.push_back(8'hCD);
    ready_block = 6;
    start(1'b0, 1'b1, 8'h10, 9'd1);
    check("dp_addr", addr_file, 8'h10);
    check("dp_we", write_en_file, 0);
    check("dp_valid_t1", tx_valid, 0);
    tick();
    check("dp_valid_t2", tx_valid, 0);
    for (int i = 3; i <= 6; i++) begin
      tick();
      check("dp_hold_valid", tx_valid, 1);
      check("dp_hold_hi", tx_data, 8'hAB);
    end
    tick();
    check("dp_lo_valid", tx_valid, 1);
    check("dp_lo_data", tx_data, 8'hCD);
    tick();
    check("dp_done", done, 1);
    check("dp_done_valid", tx_valid, 0);
    tick();
    check("dp_idle", busy, 0);
    check("dp_queue_drained", exp_tx.size(), 0);

    // Pointer wrap on both load and dump.
    do_load(8'hFF, 2, 1'b0, 1'b0, 1'b0, 16'h0);
    do_dump(8'hFF, 2, 1'b0);

    // Reset during LD_LO, then during the write strobe itself.
    start(1'b1, 1'b0, 8'h40, 9'd3);
    send_byte(8'hAA);
    rx_valid = 1'b1;
    rx_data  = 8'hBB;
    #1 reset = 1'b1;
    #1;
    check("rst_mid_busy", busy, 0);
    check("rst_mid_we", write_en_file, 0);
    rx_valid = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    start(1'b1, 1'b0, 8'h50, 9'd1);
    send_byte(8'hC3);
    send_byte(8'h3C);
    #1 reset = 1'b1;
    #1;
    check("rst_strobe_we", write_en_file, 0);
    check("rst_strobe_busy", busy, 0);
    check("rst_strobe_addr", addr_file, 0);
    tick();
    reset = 1'b0;
    tick();
    do_load(8'h40, 3, 1'b0, 1'b0, 1'b0, 16'h0);
    do_dump(8'h40, 3, 1'b0);

    // Full-memory load and dump under random backpressure.
    ready_rand = 1'b1;
    b = 8'($urandom);
    do_load(b, 256, 1'b0, 1'b0, 1'b0, 16'h0);
    do_dump(8'($urandom), 256, 1'b0);

    // Start edge cases.
    do_load(8'h20, 0, 1'b0, 1'b0, 1'b0, 16'h0);
    do_dump(8'h30, 0, 1'b0);
    do_load(8'h60, 2, 1'b1, 1'b1, 1'b0, 16'h0);
    do_dump(8'h60, 2, 1'b1);

    // Random mix.
    for (int k = 0; k < 12; k++) begin
      b = 8'($urandom);
      if ($urandom_range(0, 1) == 1)
        do_load(b, $urandom_range(0, 5), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                1'b0, 16'h0);
      else
        do_dump(b, $urandom_range(0, 5), 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 3)) tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
